// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: out = x*y + cin, unsigned or two's complement.
// One multiplier bit is consumed per CALC cycle; the result is published only
// on the edge entering DONE, so partial sums never appear on out.
module mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               cin,
  input  logic               sgn,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               cout
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    xs_q, xs_d;    // multiplicand, extended and shifted left each step
  logic [WIDTH-1:0] ys_q, ys_d;    // multiplier, shifted right so bit 0 is current
  logic             sgn_q, sgn_d;
  logic [PW-1:0]    acc_q, acc_d;  // running sum, seeded with cin
  logic [PW-1:0]    out_q, out_d;
  logic             cout_q, cout_d;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_step;
  logic             last;
  logic             ovf_u;
  logic             ovf_s;

  // Next-state, datapath step and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    out_d    = out_q;
    cout_d   = cout_q;

    pp       = ys_q[0] ? xs_q : '0;
    last     = (cnt_q == CW'(WIDTH - 1));
    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so its
    // partial product is subtracted rather than added.
    acc_step = (last && sgn_q) ? (acc_q - pp) : (acc_q + pp);
    ovf_u    = |acc_step[PW-1:WIDTH];
    ovf_s    = !((&acc_step[PW-1:WIDTH-1]) || !(|acc_step[PW-1:WIDTH-1]));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          xs_d    = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
          ys_d    = y;
          sgn_d   = sgn;
          acc_d   = {{(PW-1){1'b0}}, cin};
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        xs_d  = xs_q << 1;
        ys_d  = ys_q >> 1;
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          out_d   = acc_step;
          cout_d  = sgn_q ? ovf_s : ovf_u;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign out   = out_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq at WIDTH=4 with hand-computed expected results.
module tb_mult_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         sgn;
  logic         ready;
  logic         done;
  logic [2*W-1:0] out;
  logic         cout;

  int total;
  int bad;
  logic [2*W-1:0] prev_out;
  logic           prev_cout;

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .sgn   (sgn),
    .ready (ready),
    .done  (done),
    .out   (out),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE: checks latency, stability during CALC,
  // the result in DONE and the return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya,
                        input logic ca, input logic sa,
                        input logic [2*W-1:0] exp_out, input logic exp_cout);
    x = xa; y = ya; cin = ca; sgn = sa; start = 1'b1;
    tick();
    start = 1'b0;
    x = ~xa; y = ~ya; cin = ~ca; sgn = ~sa;   // must not disturb the op in flight
    check({tag, " ready_low"}, {31'b0, ready}, 32'd0);
    for (int k = 1; k <= W; k++) begin
      tick();
      if (k < W) begin
        check({tag, " calc_done"}, {31'b0, done}, 32'd0);
        check({tag, " calc_out"}, {24'b0, out}, {24'b0, prev_out});
      end else begin
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " out"}, {24'b0, out}, {24'b0, exp_out});
        check({tag, " cout"}, {31'b0, cout}, {31'b0, exp_cout});
      end
    end
    tick();
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, " ready_back"}, {31'b0, ready}, 32'd1);
    check({tag, " out_hold"}, {24'b0, out}, {24'b0, exp_out});
    prev_out  = exp_out;
    prev_cout = exp_cout;
  endtask

  logic [W-1:0]   bx [3];
  logic [W-1:0]   by [3];
  logic           bc [3];
  logic [2*W-1:0] bo [3];
  logic           bco[3];

  initial begin
    int ndone;
    total = 0; bad = 0;
    prev_out = '0; prev_cout = 1'b0;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0; sgn = 1'b0;

    // Reset state
    tick(); tick();
    check("rst ready", {31'b0, ready}, 32'd1);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst out", {24'b0, out}, 32'd0);
    check("rst cout", {31'b0, cout}, 32'd0);
    rst = 1'b0;

    // Unsigned vectors (first one accepted right after reset release)
    run_op("u 8*9+1", 4'b1000, 4'b1001, 1'b1, 1'b0, 8'b01001001, 1'b1);
    run_op("u 13*6", 4'b1101, 4'b0110, 1'b0, 1'b0, 8'b01001110, 1'b1);
    run_op("u 3*2+1", 4'b0011, 4'b0010, 1'b1, 1'b0, 8'b00000111, 1'b0);

    // Signed vectors
    run_op("s -3*6", 4'b1101, 4'b0110, 1'b0, 1'b1, 8'b11101110, 1'b1);
    run_op("s -8*-8", 4'b1000, 4'b1000, 1'b0, 1'b1, 8'b01000000, 1'b1);
    run_op("s -1*2+1", 4'b1111, 4'b0010, 1'b1, 1'b1, 8'b11111111, 1'b0);
    run_op("u 0*15+0", 4'b0000, 4'b1111, 1'b0, 1'b0, 8'b00000000, 1'b0);

    // Start pulsed again in CALC is ignored; exactly one done pulse
    x = 4'b0011; y = 4'b0010; cin = 1'b1; sgn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    x = 4'b1111; y = 4'b1111; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) begin
        ndone++;
        check("ign out", {24'b0, out}, 32'h07);
        check("ign cout", {31'b0, cout}, 32'd0);
      end
    end
    check("ign done_count", ndone, 32'd1);

    // Reset on the second CALC cycle aborts without a done pulse
    x = 4'b1101; y = 4'b0110; cin = 1'b0; sgn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready", {31'b0, ready}, 32'd1);
    check("abort out", {24'b0, out}, 32'd0);
    check("abort cout", {31'b0, cout}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) ndone++;
    end
    check("abort no_done", ndone, 32'd0);
    prev_out = '0; prev_cout = 1'b0;
    run_op("u 15*15+1", 4'b1111, 4'b1111, 1'b1, 1'b0, 8'b11100010, 1'b1);

    // Back-to-back with start held high; operands wiggle between acceptances
    bx[0] = 4'd5;  by[0] = 4'd7; bc[0] = 1'b0; bo[0] = 8'h23; bco[0] = 1'b1;
    bx[1] = 4'd2;  by[1] = 4'd3; bc[1] = 1'b1; bo[1] = 8'h07; bco[1] = 1'b0;
    bx[2] = 4'd15; by[2] = 4'd1; bc[2] = 1'b0; bo[2] = 8'h0F; bco[2] = 1'b0;
    sgn = 1'b0;
    for (int n = 0; n < 18; n++) begin
      if (n % 6 == 0) begin
        x = bx[n / 6]; y = by[n / 6]; cin = bc[n / 6];
      end else begin
        x = ~bx[n / 6]; y = ~by[n / 6]; cin = ~bc[n / 6];
      end
      start = 1'b1;
      tick();
      check($sformatf("b2b done n=%0d", n), {31'b0, done}, (n % 6 == 4) ? 32'd1 : 32'd0);
      if (n % 6 == 4) begin
        check($sformatf("b2b out k=%0d", n / 6), {24'b0, out}, {24'b0, bo[n / 6]});
        check($sformatf("b2b cout k=%0d", n / 6), {31'b0, cout}, {31'b0, bco[n / 6]});
      end
    end
    start = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
